// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, field indices and FSM states for fp_norm_round (FP_NORM_ROUND_FLAGS_EN enables flags)
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W = FRAC_W + 5;
  localparam int BIAS = 127;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int C_IDX = SIG_W - 1;
  localparam int H_IDX = SIG_W - 2;
  localparam int G_IDX = 2;
  localparam int R_IDX = 1;
  localparam int S_IDX = 0;
  typedef enum logic [2:0] {IDLE, RSHIFT, LSHIFT, ROUND, DONE} state_e;
endpackage

// File: rtl/fp_rne_round.sv
// fp_rne_round: combinational round-to-nearest-even and IEEE-754 pack with infinity saturation (flags under FP_NORM_ROUND_FLAGS_EN)
module fp_rne_round
  import fp_pkg::*;
(
  input  logic                    sign,
  input  logic [EXP_W:0]          exp_in,
  input  logic [SIG_W-1:0]        sig,
`ifdef FP_NORM_ROUND_FLAGS_EN
  output logic [2:0]              flags,
`endif
  output logic [EXP_W+FRAC_W:0]   word
);
  logic up, zero, inf;
  logic [FRAC_W+1:0] sum;
  logic [EXP_W:0] exp_r;
  logic [EXP_W-1:0] exp_f;
  logic [FRAC_W-1:0] frac_f;
  assign up = sig[G_IDX] & (sig[R_IDX] | sig[S_IDX] | sig[G_IDX+1]);
  assign sum = {1'b0, sig[H_IDX:G_IDX+1]} + (FRAC_W+2)'(up);
  assign exp_r = exp_in + (EXP_W+1)'(sum[FRAC_W+1]);
  assign zero = ~|sig;
  assign inf = exp_r >= (EXP_W+1)'(EXP_MAX);
  assign exp_f = inf ? EXP_W'(EXP_MAX) : |sum[FRAC_W+1:FRAC_W] ? exp_r[EXP_W-1:0] : '0;
  assign frac_f = (inf || sum[FRAC_W+1]) ? '0 : sum[FRAC_W-1:0];
  assign word = {sign & ~zero, exp_f, frac_f};
`ifdef FP_NORM_ROUND_FLAGS_EN
  logic inexact;
  assign inexact = sig[G_IDX] | sig[R_IDX] | sig[S_IDX] | inf;
  assign flags = {inf, ~|exp_f & inexact, inexact};
`endif
endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: iterative normalize, RNE round and pack for the FP adder back end (FP_NORM_ROUND_FLAGS_EN adds flags port)
module fp_norm_round
  import fp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [SIG_W-1:0]        in_sig,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef FP_NORM_ROUND_FLAGS_EN
  output logic [2:0]              flags,
`endif
  output logic [EXP_W+FRAC_W:0]   out_word
);
  localparam logic [EXP_W:0] ONE = (EXP_W+1)'(1);
  state_e state_q, state_d;
  logic sign_q, sign_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [EXP_W+FRAC_W:0] word_q, word_d, rnd_word;
`ifdef FP_NORM_ROUND_FLAGS_EN
  logic [2:0] flags_q, flags_d, rnd_flags;
`endif
  fp_rne_round u_rnd (
    .sign   (sign_q),
    .exp_in (exp_q),
    .sig    (sig_q),
`ifdef FP_NORM_ROUND_FLAGS_EN
    .flags  (rnd_flags),
`endif
    .word   (rnd_word)
  );
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    exp_d = exp_q;
    sig_d = sig_q;
    word_d = word_q;
`ifdef FP_NORM_ROUND_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = in_sign;
        exp_d = {1'b0, in_exp};
        sig_d = in_sig;
        state_d = ~|in_sig ? ROUND : in_sig[C_IDX] ? RSHIFT : in_sig[H_IDX] ? ROUND : LSHIFT;
      end
      RSHIFT: begin
        sig_d = {1'b0, sig_q[SIG_W-1:2], |sig_q[1:0]};
        exp_d = exp_q + ONE;
        state_d = ROUND;
      end
      LSHIFT: begin
        if (exp_q > ONE) begin
          sig_d = {sig_q[SIG_W-2:0], 1'b0};
          exp_d = exp_q - ONE;
        end
        state_d = (sig_d[H_IDX] || exp_d == ONE) ? ROUND : LSHIFT;
      end
      ROUND: begin
        word_d = rnd_word;
`ifdef FP_NORM_ROUND_FLAGS_EN
        flags_d = rnd_flags;
`endif
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      exp_q <= '0;
      sig_q <= '0;
      word_q <= '0;
`ifdef FP_NORM_ROUND_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      sig_q <= sig_d;
      word_q <= word_d;
`ifdef FP_NORM_ROUND_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_word = word_q;
`ifdef FP_NORM_ROUND_FLAGS_EN
  assign flags = flags_q;
`endif
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed self-checking bench for fp_norm_round (flags checked when FP_NORM_ROUND_FLAGS_EN is defined)
module tb_fp_norm_round;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [7:0] in_exp;
  logic [27:0] in_sig;
  logic [31:0] out_word;
  int n_cmp = 0;
  int n_err = 0;
`ifdef FP_NORM_ROUND_FLAGS_EN
  logic [2:0] flags;
`endif
  fp_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP_NORM_ROUND_FLAGS_EN
    .flags     (flags),
`endif
    .out_word  (out_word)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic logic [27:0] mk(input logic c, input logic h, input logic [22:0] f, input logic g, input logic r, input logic s);
    return {c, h, f, g, r, s};
  endfunction
  task automatic run(input string tag, input logic sg, input logic [7:0] e, input logic [27:0] s, input logic [31:0] w, input int lat_want, input logic [2:0] fl, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign = sg;
    in_exp = e;
    in_sig = s;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'(lat_want));
    chk({tag, "_word"}, 64'(out_word), 64'(w));
`ifdef FP_NORM_ROUND_FLAGS_EN
    chk({tag, "_flags"}, 64'(flags), 64'(fl));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_sig = ~s;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_word"}, 64'(out_word), 64'(w));
      chk({tag, "_hold_hs"}, 64'({out_valid, in_ready}), 64'(2'b10));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    logic seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exp = '0;
    in_sig = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    chk("reset_word", 64'(out_word), 64'h0);
    run("one_plus_one", 1'b0, 8'd127, mk(1, 0, 23'h0, 0, 0, 0), 32'h40000000, 3, 3'b000, 0);
    run("cancel", 1'b0, 8'd127, mk(0, 0, 23'h1, 0, 0, 0), 32'h34000000, 25, 3'b000, 0);
    run("tie_ovf", 1'b0, 8'd127, mk(0, 1, 23'h7FFFFF, 1, 0, 0), 32'h40000000, 2, 3'b001, 0);
    run("tie_even", 1'b0, 8'd127, mk(0, 1, 23'h0, 1, 0, 0), 32'h3F800000, 2, 3'b001, 0);
    run("round_up", 1'b0, 8'd127, mk(0, 1, 23'h0, 1, 0, 1), 32'h3F800001, 2, 3'b001, 0);
    run("negative", 1'b1, 8'd128, mk(0, 1, 23'h200000, 0, 0, 0), 32'hC0200000, 2, 3'b000, 0);
    run("carry_grs", 1'b0, 8'd127, mk(1, 0, 23'h1, 1, 0, 0), 32'h40000001, 3, 3'b001, 0);
    run("overflow", 1'b0, 8'd254, mk(1, 0, 23'h0, 0, 0, 0), 32'h7F800000, 3, 3'b101, 0);
    run("denorm", 1'b0, 8'd1, mk(0, 0, 23'h400000, 0, 0, 0), 32'h00400000, 3, 3'b000, 0);
    run("denorm_rnd", 1'b0, 8'd1, mk(0, 0, 23'h0, 1, 1, 0), 32'h00000001, 3, 3'b011, 0);
    run("zero", 1'b1, 8'd100, 28'h0, 32'h00000000, 2, 3'b000, 0);
    run("hold", 1'b0, 8'd127, mk(0, 1, 23'h0, 0, 0, 0), 32'h3F800000, 2, 3'b000, 5);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign = 1'b0;
    in_exp = 8'd127;
    in_sig = mk(0, 0, 23'h1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("lshift_busy", 64'({out_valid, in_ready}), 64'(2'b00));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    chk("abort_word", 64'(out_word), 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale", 64'(seen), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Back end of the single-precision FP adder datapath; the counterpart of the exponent-difference/alignment front end (smallAlu plus the right shifter).
- Accepts the raw post-add significand with its tentative exponent and sign.
- Normalizes iteratively: one right shift on carry-out, or left shifts one per cycle until the hidden bit is set or the exponent floor is reached.
- Rounds round-to-nearest-even and packs an IEEE-754 word. Valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width (biased).
- FRAC_W, 23, stored fraction width.
- SIG_W, FRAC_W+5, raw significand width: carry, hidden, fraction, G, R, S.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept an input (high only in IDLE).
- in_sign  in  1  result sign from the adder.
- in_exp  in  EXP_W  tentative biased exponent; caller guarantees 1..2^EXP_W-2.
- in_sig  in  SIG_W  {carry, hidden, frac[FRAC_W-1:0], G, R, S}.
- out_valid  out  1  packed result available.
- out_ready  in  1  consumer accepts the result.
- out_word  out  1+EXP_W+FRAC_W  {sign, exp, frac}.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_word=0, all internal registers 0. Reset mid-operation aborts the result; it is never emitted.
- FSM states: IDLE, RSHIFT, LSHIFT, ROUND, DONE.
- IDLE:
  - On in_valid && in_ready, capture sign, exp and sig.
  - Next state:
    - sig==0 → ROUND.
    - carry=1 → RSHIFT.
    - hidden=1 → ROUND.
    - otherwise → LSHIFT.
- RSHIFT, 1 cycle: sig >>= 1 with S |= shifted-out bit; exp += 1; → ROUND.
- LSHIFT, 1 cycle per shift: while hidden==0 and exp>1, sig <<= 1 (zero fill) and exp -= 1. → ROUND when hidden==1 or exp==1.
- Denormal result: hidden==0 at exp==1 encodes exponent field 0.
- ROUND, 1 cycle:
  - Round up when G && (R || S || frac LSB).
  - Fraction overflow on round-up: hidden becomes set (denormal → exp field 1) or carry out (exp += 1, frac=0).
  - exp ≥ 2^EXP_W-1 → ±infinity (exp all ones, frac=0).
  - sig==0 → +0 (sign forced 0).
  - Register out_word; → DONE.
- DONE: out_valid=1, out_word stable while out_ready=0. On out_ready, clear out_valid and go to IDLE. Earliest next accept is the following cycle (no bypass).
- Latency from accept to out_valid: 2 cycles for the no-shift path, 3 for the carry path, 2+k for k left shifts (max FRAC_W+1).
- in_ready is 0 in every state except IDLE; in_valid outside IDLE is ignored.

Optional Feature:
- Macro FP_NORM_ROUND_FLAGS_EN.
- Defined: adds output port flags[2:0] = {overflow, underflow, inexact}, registered alongside out_word and valid with out_valid.
  - inexact = G|R|S at round, or overflow.
  - underflow = denormal/zero result and inexact.
  - overflow = infinity produced.
- Undefined: port absent, no flag logic.

Decomposition:
- Package fp_pkg: EXP_W, FRAC_W, SIG_W, BIAS=127, EXP_MAX; state enum; field-index constants for carry/hidden/G/R/S.
- One natural sub-module, fp_rne_round: combinational RNE increment plus overflow/infinity pack, instantiated in ROUND.

Test Plan:
- 1.0+1.0: exp=127, sig carry=1, rest 0 → out_word 0x40000000 after 3 cycles.
- Cancellation: exp=127, hidden=0, frac=1, GRS=0 → 23 left shifts, out_word 0x34000000, latency 25.
- Tie rounding: exp=127, hidden=1, frac=all ones, G=1, R=S=0 → round-up overflow, out_word 0x40000000.
- Overflow: exp=254, carry=1 → 0x7F800000; with FLAGS_EN, flags=3'b101.
- Denormal/zero:
  - exp=1, hidden=0, frac=0x400000 → 0x00400000.
  - sig=0 with sign=1 → 0x00000000.
- Handshake/reset: hold out_ready=0 for 5 cycles → out_word stable and in_ready=0. Assert rst_n=0 during LSHIFT → next cycle IDLE, out_valid=0, no stale output afterwards.
